// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_pkg
//  Description : Shared AHB-Lite encodings (HTRANS, HRESP, HSIZE), slave FSM
//                state type and byte-lane helper functions.
//  Revision    : 1.0 - initial release
// ============================================================================
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    localparam logic [2:0] HSIZE_BYTE    = 3'd0;
    localparam logic [2:0] HSIZE_HALF    = 3'd1;
    localparam logic [2:0] HSIZE_WORD    = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DATA = 3'd1,
        ST_WAIT = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } ahb_state_t;

    // Little-endian byte lanes touched by a transfer of the given size.
    function automatic logic [3:0] byte_lanes(input logic [1:0] lo, input logic [2:0] size);
        logic [3:0] lanes;
        lanes = 4'b1111;
        case (size)
            HSIZE_BYTE: lanes = 4'b0001 << lo;
            HSIZE_HALF: lanes = lo[1] ? 4'b1100 : 4'b0011;
            default:    lanes = 4'b1111;
        endcase
        return lanes;
    endfunction

    // True when the low address bits are not a multiple of the transfer size.
    function automatic logic size_misaligned(input logic [1:0] lo, input logic [2:0] size);
        logic mis;
        mis = 1'b0;
        case (size)
            HSIZE_HALF: mis = lo[0];
            HSIZE_WORD: mis = |lo;
            default:    mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_slv_mem.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_slv_mem
//  Description : MEM_DEPTH x 32 word storage with a byte-enable write port and
//                a registered read port (one cycle read latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_slv_mem #(
    parameter int MEM_DEPTH = 256,
    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] r_mem [MEM_DEPTH];
    logic [31:0] r_rdata;

    // Byte-lane write; storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    r_mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Registered read port; a same-edge write is not visible until the next read.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/ahb_lite_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_lite_sram_slave
//  Description : AHB-Lite responder backed by an internal word memory.
//                Address-phase capture, legality check, response FSM,
//                optional NONSEQ wait states and read-after-write forwarding.
//                Build option: define AHB_SLV_WAIT_EN to insert WAIT_CYCLES
//                wait states on every legal NONSEQ transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_lite_sram_slave
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [DATA_WIDTH-1:0] hwdata,
    input  logic                  hready,
    output logic                  hreadyout,
    output logic [1:0]            hresp,
    output logic [DATA_WIDTH-1:0] hrdata
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    ahb_state_t    r_state;
    ahb_state_t    w_next;

    logic          w_active;
    logic          w_accept;
    logic [AW-1:0] w_idx;
    logic          w_range_err;
    logic          w_illegal;
    logic          w_wait_go;
    logic          w_wait_done;

    logic [AW-1:0] r_idx;
    logic [1:0]    r_lo;
    logic [2:0]    r_size;
    logic          r_write;

    logic          w_mem_we;
    logic [3:0]    w_be;
    logic [AW-1:0] w_raddr;
    logic [31:0]   w_mem_rdata;

    logic          r_fwd_hit;
    logic [3:0]    r_fwd_be;
    logic [31:0]   r_fwd_data;

    assign w_active = !((htrans == HTRANS_IDLE) || (htrans == HTRANS_BUSY));
    assign w_accept = hsel && hready && w_active;
    assign w_idx    = haddr[AW+1:2];

    // Index range check is only needed when the depth does not fill the index field.
    generate
        if ((1 << AW) == MEM_DEPTH) begin : g_range_pow2
            assign w_range_err = 1'b0;
        end else begin : g_range_partial
            assign w_range_err = (w_idx >= AW'(MEM_DEPTH));
        end
    endgenerate

    assign w_illegal = (hsize > HSIZE_WORD) || size_misaligned(haddr[1:0], hsize) || w_range_err;

`ifdef AHB_SLV_WAIT_EN
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] C_WAIT_LOAD = CW'(WAIT_CYCLES - 1);

    logic [CW-1:0] r_wait_cnt;

    // Wait-state down-counter, loaded at every accept and run only in WAIT.
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            r_wait_cnt <= '0;
        end else if (w_accept) begin
            r_wait_cnt <= C_WAIT_LOAD;
        end else if ((r_state == ST_WAIT) && (r_wait_cnt != '0)) begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
        end
    end

    assign w_wait_go   = (htrans == HTRANS_NONSEQ) && (WAIT_CYCLES > 0);
    assign w_wait_done = (r_wait_cnt == '0);
`else
    logic w_unused_wait_ok;
    assign w_unused_wait_ok = (WAIT_CYCLES != 0);
    assign w_wait_go        = 1'b0;
    assign w_wait_done      = 1'b1;
`endif

    logic w_unused_ok;
    assign w_unused_ok = ^{hburst, haddr[ADDR_WIDTH-1:AW+2]};

    // Address-phase register: captured whenever a transfer is accepted.
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            r_idx   <= '0;
            r_lo    <= '0;
            r_size  <= HSIZE_BYTE;
            r_write <= 1'b0;
        end else if (w_accept) begin
            r_idx   <= w_idx;
            r_lo    <= haddr[1:0];
            r_size  <= hsize;
            r_write <= hwrite;
        end
    end

    // FSM state register.
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and bus response decode.
    always_comb begin
        w_next    = r_state;
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        case (r_state)
            ST_WAIT: begin
                hreadyout = 1'b0;
                if (w_wait_done) begin
                    w_next = ST_DATA;
                end
            end
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
                w_next    = ST_ERR2;
            end
            default: begin
                if (r_state == ST_ERR2) begin
                    hresp = HRESP_ERROR;
                end
                if (w_accept) begin
                    if (w_illegal) begin
                        w_next = ST_ERR1;
                    end else if (w_wait_go) begin
                        w_next = ST_WAIT;
                    end else begin
                        w_next = ST_DATA;
                    end
                end else begin
                    w_next = ST_IDLE;
                end
            end
        endcase
    end

    // A write lands at the end of its DATA cycle; a reset on that edge discards it.
    assign w_mem_we = hresetn && (r_state == ST_DATA) && r_write;
    assign w_be     = byte_lanes(r_lo, r_size);
    // Read address comes straight from the bus at accept so data is ready in the data phase.
    assign w_raddr  = w_accept ? w_idx : r_idx;

    ahb_slv_mem #(
        .MEM_DEPTH (MEM_DEPTH)
    ) u_mem (
        .clk    (hclk),
        .resetn (hresetn),
        .we     (w_mem_we),
        .be     (w_be),
        .waddr  (r_idx),
        .wdata  (hwdata),
        .raddr  (w_raddr),
        .rdata  (w_mem_rdata)
    );

    // Forwarding capture: a read accepted on the edge that commits a write to the same word.
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            r_fwd_hit  <= 1'b0;
            r_fwd_be   <= '0;
            r_fwd_data <= '0;
        end else begin
            r_fwd_hit  <= w_mem_we && w_accept && !hwrite && (w_idx == r_idx);
            r_fwd_be   <= w_be;
            r_fwd_data <= hwdata;
        end
    end

    // Read data: memory word with freshly written lanes merged in for one cycle.
    always_comb begin
        hrdata = w_mem_rdata;
        if (r_fwd_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (r_fwd_be[i]) begin
                    hrdata[8*i +: 8] = r_fwd_data[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb_lite_sram_slave
//  Description : Self-checking bench for ahb_lite_sram_slave. Directed AHB
//                transfers push their expected responses into a queue; a
//                monitor pops and compares at every completed data phase.
//                Wait-state scenarios are included when AHB_SLV_WAIT_EN is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_lite_sram_slave;
    import ahb_pkg::*;

`ifdef AHB_SLV_WAIT_EN
    localparam int EXP_WAIT = 2;
`else
    localparam int EXP_WAIT = 0;
`endif

    logic        hclk    = 1'b0;
    logic        hresetn = 1'b0;
    logic        hsel    = 1'b0;
    logic [31:0] haddr   = '0;
    logic [1:0]  htrans  = HTRANS_IDLE;
    logic        hwrite  = 1'b0;
    logic [2:0]  hsize   = HSIZE_WORD;
    logic [2:0]  hburst  = 3'b000;
    logic [31:0] hwdata  = '0;
    logic        hready;
    logic        hreadyout;
    logic [1:0]  hresp;
    logic [31:0] hrdata;

    assign hready = hreadyout;

    always #5 hclk = ~hclk;

    ahb_lite_sram_slave #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .MEM_DEPTH   (256),
        .WAIT_CYCLES (2)
    ) dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .hsel      (hsel),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hburst    (hburst),
        .hwdata    (hwdata),
        .hready    (hready),
        .hreadyout (hreadyout),
        .hresp     (hresp),
        .hrdata    (hrdata)
    );

    typedef struct {
        string       name;
        logic [1:0]  resp;
        bit          chk;
        logic [31:0] data;
        int          stalls;
    } exp_t;

    exp_t        q[$];
    int          total   = 0;
    int          bad     = 0;
    logic [31:0] pend_wd = '0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Hold the current address phase until the bus is ready, then cross the edge.
    task automatic wait_ready();
        int g;
        g = 0;
        @(negedge hclk);
        while (!hreadyout) begin
            g++;
            if (g > 40) begin
                $display("FAIL timeout: hreadyout stuck low got 0 expected 1");
                $fatal(1, "bus hang");
            end
            @(negedge hclk);
        end
        @(posedge hclk);
        #1;
    endtask

    task automatic beat(input string name, input logic [31:0] a, input bit w, input logic [2:0] sz,
                        input logic [1:0] tr, input logic [31:0] wd, input logic [1:0] eresp,
                        input bit chk, input logic [31:0] edata, input int estall);
        exp_t e;
        e.name = name; e.resp = eresp; e.chk = chk; e.data = edata; e.stalls = estall;
        q.push_back(e);
        hsel = 1'b1; haddr = a; hwrite = w; hsize = sz; htrans = tr; hwdata = pend_wd;
        wait_ready();
        pend_wd = wd;
    endtask

    task automatic wr(input string name, input logic [31:0] a, input logic [2:0] sz,
                      input logic [1:0] tr, input logic [31:0] wd);
        beat(name, a, 1'b1, sz, tr, wd, HRESP_OKAY, 1'b0, 32'h0, (tr == HTRANS_NONSEQ) ? EXP_WAIT : 0);
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [1:0] tr, input logic [31:0] ed);
        beat(name, a, 1'b0, HSIZE_WORD, tr, 32'h0, HRESP_OKAY, 1'b1, ed, (tr == HTRANS_NONSEQ) ? EXP_WAIT : 0);
    endtask

    task automatic err(input string name, input logic [31:0] a, input bit w, input logic [2:0] sz,
                       input logic [31:0] wd);
        beat(name, a, w, sz, HTRANS_NONSEQ, wd, HRESP_ERROR, 1'b0, 32'h0, 1);
    endtask

    task automatic idle();
        hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0; hwdata = pend_wd;
        wait_ready();
        pend_wd = '0;
    endtask

    // Monitor: tracks data phases from bus signals and checks each completion.
    bit         dp  = 1'b0;
    int         stl = 0;
    logic [1:0] sresp = '0;
    exp_t       me;

    always @(negedge hclk) begin
        if (!hresetn) begin
            dp  = 1'b0;
            stl = 0;
        end else begin
            if (dp) begin
                if (!hreadyout) begin
                    if (stl == 0) sresp = hresp;
                    stl++;
                end else begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_completion: got resp %0d expected no transfer", hresp);
                    end else begin
                        me = q.pop_front();
                        cmp({me.name, ".resp"}, 32'(hresp), 32'(me.resp));
                        if (me.chk) cmp({me.name, ".data"}, hrdata, me.data);
                        cmp({me.name, ".stalls"}, 32'(stl), 32'(me.stalls));
                        if (me.stalls > 0) cmp({me.name, ".stall_resp"}, 32'(sresp), 32'(me.resp));
                    end
                    dp  = 1'b0;
                    stl = 0;
                end
            end
            if (hreadyout && hsel && htrans[1]) dp = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        hresetn = 1'b0;
        repeat (3) @(posedge hclk);
        @(negedge hclk);
        cmp("rst.hreadyout", 32'(hreadyout), 32'd1);
        cmp("rst.hresp",     32'(hresp),     32'd0);
        cmp("rst.hrdata",    hrdata,         32'd0);
        @(posedge hclk); #1;
        hresetn = 1'b1;

        // Single word write then read
        wr("t1.wr", 32'h4000_0010, HSIZE_WORD, HTRANS_NONSEQ, 32'd11);
        idle();
        rd("t1.rd", 32'h4000_0010, HTRANS_NONSEQ, 32'd11);
        idle();

        // INCR4 write and read back
        hburst = 3'b011;
        wr("t2.w0", 32'h4000_0090, HSIZE_WORD, HTRANS_NONSEQ, 32'd50);
        wr("t2.w1", 32'h4000_0094, HSIZE_WORD, HTRANS_SEQ,    32'd51);
        wr("t2.w2", 32'h4000_0098, HSIZE_WORD, HTRANS_SEQ,    32'd53);
        wr("t2.w3", 32'h4000_009C, HSIZE_WORD, HTRANS_SEQ,    32'd58);
        idle();
        rd("t2.r0", 32'h4000_0090, HTRANS_NONSEQ, 32'd50);
        rd("t2.r1", 32'h4000_0094, HTRANS_SEQ,    32'd51);
        rd("t2.r2", 32'h4000_0098, HTRANS_SEQ,    32'd53);
        rd("t2.r3", 32'h4000_009C, HTRANS_SEQ,    32'd58);
        idle();
        hburst = 3'b000;

        // Byte write into lane 1; other hwdata lanes must be ignored
        wr("t3.word", 32'h4000_0020, HSIZE_WORD, HTRANS_NONSEQ, 32'h1122_3344);
        idle();
        wr("t3.byte", 32'h4000_0021, HSIZE_BYTE, HTRANS_NONSEQ, 32'h5566_AB77);
        idle();
        rd("t3.rd", 32'h4000_0020, HTRANS_NONSEQ, 32'h1122_AB44);
        idle();

        // Illegal transfers: two-cycle ERROR, memory untouched
        wr("t4.init", 32'h4000_001C, HSIZE_WORD, HTRANS_NONSEQ, 32'hCAFE_F00D);
        idle();
        err("t4.mis_word", 32'h4000_001E, 1'b1, HSIZE_WORD, 32'hFFFF_FFFF);
        idle();
        rd("t4.rd0", 32'h4000_001C, HTRANS_NONSEQ, 32'hCAFE_F00D);
        err("t4.size3",    32'h4000_001C, 1'b0, 3'd3,       32'h0);
        err("t4.half_odd", 32'h4000_001D, 1'b1, HSIZE_HALF, 32'hFFFF_FFFF);
        rd("t4.rd1", 32'h4000_001C, HTRANS_NONSEQ, 32'hCAFE_F00D);
        idle();

        // Read directly behind a write to the same word
        wr("t5.wr", 32'h4000_0068, HSIZE_WORD, HTRANS_NONSEQ, 32'd90);
        rd("t5.fwd", 32'h4000_0068, HTRANS_NONSEQ, 32'd90);
        idle();
        wr("t5.base", 32'h4000_006C, HSIZE_WORD, HTRANS_NONSEQ, 32'hAABB_CCDD);
        idle();
        wr("t5.half", 32'h4000_006E, HSIZE_HALF, HTRANS_NONSEQ, 32'h1234_FFFF);
        rd("t5.fwd_half", 32'h4000_006C, HTRANS_NONSEQ, 32'h1234_CCDD);
        idle();
        rd("t5.mem_half", 32'h4000_006C, HTRANS_NONSEQ, 32'h1234_CCDD);
        idle();

`ifdef AHB_SLV_WAIT_EN
        // NONSEQ stalls, SEQ beats do not; hsel dropped mid-wait still completes
        rd("t6.ns",  32'h4000_0090, HTRANS_NONSEQ, 32'd50);
        rd("t6.s1",  32'h4000_0094, HTRANS_SEQ,    32'd51);
        rd("t6.s2",  32'h4000_0098, HTRANS_SEQ,    32'd53);
        idle();
        rd("t6.hsel_drop", 32'h4000_009C, HTRANS_NONSEQ, 32'd58);
        idle();

        // Reset while in WAIT aborts the transfer
        hsel = 1'b1; haddr = 32'h4000_0090; hwrite = 1'b0; hsize = HSIZE_WORD; htrans = HTRANS_NONSEQ;
        hwdata = pend_wd;
        wait_ready();
        hsel = 1'b0; htrans = HTRANS_IDLE;
        hresetn = 1'b0;
        @(negedge hclk);
        cmp("t6.in_wait.hreadyout", 32'(hreadyout), 32'd0);
        @(posedge hclk); #1;
        hresetn = 1'b1;
        pend_wd = '0;
        @(negedge hclk);
        cmp("t6.post_rst.hreadyout", 32'(hreadyout), 32'd1);
        cmp("t6.post_rst.hresp",     32'(hresp),     32'd0);
        @(posedge hclk); #1;
        rd("t6.after_rst", 32'h4000_0090, HTRANS_NONSEQ, 32'd50);
        idle();
`endif

        g = 0;
        while ((q.size() != 0) && (g < 20)) begin
            @(posedge hclk);
            g++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d outstanding expected 0", q.size());
        end
        repeat (2) @(posedge hclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
